// File: rtl/sd_pkg.sv
// Shared types and constants for the SD access arbiter: FSM state encoding,
// sector/bus sizes and a helper for index widths.
package sd_pkg;

   localparam int SECTOR_BYTES = 512;
   localparam int SD_ADDR_W    = 32;
   localparam int SD_DATA_W    = 16;

   typedef enum logic [2:0] {
      WAIT_INIT,
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE,
      DONE
   } state_t;

   // Width of an index able to address n requesters (at least one bit).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sd_access_arbiter_if.sv
// Bundle of the single SD controller's sector read/write interface.
// master = arbiter side, slave = controller side.
interface sd_access_arbiter_if;
   import sd_pkg::*;

   logic                 write_start;
   logic [SD_ADDR_W-1:0] write_addr;
   logic [SD_DATA_W-1:0] write_data;
   logic                 write_busy;
   logic                 write_request;
   logic                 read_start;
   logic [SD_ADDR_W-1:0] read_addr;
   logic                 read_busy;
   logic                 read_enable;
   logic [SD_DATA_W-1:0] read_data;

   modport master (
      output write_start, write_addr, write_data, read_start, read_addr,
      input  write_busy, write_request, read_busy, read_enable, read_data
   );

   modport slave (
      input  write_start, write_addr, write_data, read_start, read_addr,
      output write_busy, write_request, read_busy, read_enable, read_data
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins,
// returned both as a one-hot vector and as an index.
module rr_arbiter
   import sd_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            any
);

   int          pos;
   logic [IW-1:0] sel;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      pos = 0;
      sel = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = int'(ptr) + k;
         if (pos >= NREQ) pos = pos - NREQ;
         sel = pos[IW-1:0];
         if (!any && req[sel]) begin
            any      = 1'b1;
            gnt[sel] = 1'b1;
            idx      = sel;
         end
      end
   end

endmodule

// File: rtl/sd_access_arbiter.sv
// Round-robin arbiter sharing one SD controller between NREQ requesters,
// one sector transaction at a time, with init gating and a completion timeout.
module sd_access_arbiter
   import sd_pkg::*;
#(
   parameter int NREQ        = 2,
   parameter int TIMEOUT_CYC = 2000000,
   parameter int TW          = 21
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      init_done,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ-1:0]           req_we,
   input  logic [SD_ADDR_W*NREQ-1:0] req_addr,
   input  logic [SD_DATA_W*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]           gnt,
   output logic [NREQ-1:0]           done,
   output logic [NREQ-1:0]           err,
   output logic [NREQ-1:0]           wdata_req,
   output logic [NREQ-1:0]           rdata_valid,
   output logic [SD_DATA_W-1:0]      rdata,
   sd_access_arbiter_if.master       sd,
   output state_t                    fsm_state
);

   localparam int IW = idx_w(NREQ);

   state_t               state, state_next;
   logic [NREQ-1:0]      gnt_q, done_q, err_q;
   logic [IW-1:0]        owner, rr;
   logic                 we_q;
   logic [SD_ADDR_W-1:0] write_addr_q, read_addr_q, sel_addr;
   logic [SD_DATA_W-1:0] wdata_mux;
   logic [TW-1:0]        cnt;

   logic [NREQ-1:0]      arb_gnt;
   logic [IW-1:0]        arb_idx;
   logic                 arb_any;

   logic                 grant_set, finish, finish_err, busy_sel, timeout_hit;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
      .req (req),
      .ptr (rr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign busy_sel    = we_q ? sd.write_busy : sd.read_busy;
   // Counter is cleared in START, so the abort lands TIMEOUT_CYC cycles after the start pulse.
   assign timeout_hit = (cnt == TW'(TIMEOUT_CYC - 2));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= WAIT_INIT;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      grant_set  = 1'b0;
      finish     = 1'b0;
      finish_err = 1'b0;
      if (!init_done) begin
         state_next = WAIT_INIT;
         if (state == START || state == WAIT_BUSY || state == WAIT_DONE) begin
            finish     = 1'b1;
            finish_err = 1'b1;
         end
      end else begin
         case (state)
            WAIT_INIT: state_next = IDLE;
            IDLE: begin
               if (arb_any) begin
                  state_next = START;
                  grant_set  = 1'b1;
               end
            end
            START: state_next = WAIT_BUSY;
            WAIT_BUSY: begin
               if (busy_sel) begin
                  state_next = WAIT_DONE;
               end else if (timeout_hit) begin
                  state_next = DONE;
                  finish     = 1'b1;
                  finish_err = 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!busy_sel) begin
                  state_next = DONE;
                  finish     = 1'b1;
               end else if (timeout_hit) begin
                  state_next = DONE;
                  finish     = 1'b1;
                  finish_err = 1'b1;
               end
            end
            // Never hand the controller a new start while it still reports busy.
            DONE: begin
               if (!sd.write_busy && !sd.read_busy) state_next = IDLE;
            end
            default: state_next = WAIT_INIT;
         endcase
      end
   end

   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_idx == IW'(i)) sel_addr = req_addr[i*SD_ADDR_W +: SD_ADDR_W];
      end
   end

   always_comb begin
      wdata_mux = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_q[i]) wdata_mux = req_wdata[i*SD_DATA_W +: SD_DATA_W];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_q        <= '0;
         done_q       <= '0;
         err_q        <= '0;
         owner        <= '0;
         rr           <= '0;
         we_q         <= 1'b0;
         write_addr_q <= '0;
         read_addr_q  <= '0;
         cnt          <= '0;
      end else begin
         if (grant_set) begin
            gnt_q <= arb_gnt;
            owner <= arb_idx;
            we_q  <= req_we[arb_idx];
            if (req_we[arb_idx]) write_addr_q <= sel_addr;
            else                 read_addr_q  <= sel_addr;
         end
         if (finish) begin
            gnt_q  <= '0;
            done_q <= gnt_q;
            err_q  <= finish_err ? gnt_q : '0;
            rr     <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
         end else begin
            done_q <= '0;
            err_q  <= '0;
         end
         if (state == START)
            cnt <= '0;
         else if (state == WAIT_BUSY || state == WAIT_DONE)
            cnt <= cnt + 1'b1;
      end
   end

   assign gnt            = gnt_q;
   assign done           = done_q;
   assign err            = err_q;
   assign wdata_req      = gnt_q & {NREQ{sd.write_request}};
   assign rdata_valid    = gnt_q & {NREQ{sd.read_enable}};
   assign rdata          = sd.read_data;
   assign sd.write_start = (state == START) && we_q;
   assign sd.read_start  = (state == START) && !we_q;
   assign sd.write_addr  = write_addr_q;
   assign sd.read_addr   = read_addr_q;
   assign sd.write_data  = wdata_mux;
   assign fsm_state      = state;

endmodule
